mem_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares the single-port 16x16 memory (rd_en/wr_en/addr/wdata/rdata) between two independent clients.
- Accepts one access per cycle via valid/ready handshakes and drives registered memory controls.
- Returns read data to the requester that issued the read, tagged through a latency-matched pipeline.
- Sits between the client masters and the memory, on the memory's clock.

---
 rtl/mem_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_rr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin front end for a single-port memory.
// Issues one registered access per cycle and routes read data back to the requester that issued the read.
module mem_rr_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              r0_valid_i,
  output logic              r0_ready_o,
  input  logic              r0_we_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_rsp_valid_o,
  output logic [DATA_W-1:0] r0_rsp_rdata_o,
  input  logic              r1_valid_i,
  output logic              r1_ready_o,
  input  logic              r1_we_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_rsp_valid_o,
  output logic [DATA_W-1:0] r1_rsp_rdata_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic              ptr_q, ptr_d;
  logic              grant0, grant1, anyGrant;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  logic              memRdEn_q, memWrEn_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;

  // Tag stage k describes the read whose controls were on the memory k cycles ago.
  logic [RD_LATENCY:0] tagVld_q, tagId_q;

  logic              r0RspValid_q, r1RspValid_q;
  logic [DATA_W-1:0] r0RspRdata_q, r1RspRdata_q;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset_i) begin
      if (r0_valid_i && (!r1_valid_i || !ptr_q)) begin
        grant0 = 1'b1;
      end else if (r1_valid_i) begin
        grant1 = 1'b1;
      end
    end
    anyGrant = grant0 | grant1;
    ptr_d    = ptr_q;
    if (grant0) begin
      ptr_d = 1'b1;
    end else if (grant1) begin
      ptr_d = 1'b0;
    end
    selWe    = grant1 ? r1_we_i    : r0_we_i;
    selAddr  = grant1 ? r1_addr_i  : r0_addr_i;
    selWdata = grant1 ? r1_wdata_i : r0_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q      <= 1'b0;
      memRdEn_q  <= 1'b0;
      memWrEn_q  <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      tagVld_q   <= '0;
      tagId_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      memRdEn_q <= anyGrant & ~selWe;
      memWrEn_q <= anyGrant & selWe;
      if (anyGrant) begin
        memAddr_q  <= selAddr;
        memWdata_q <= selWdata;
      end
      tagVld_q <= {tagVld_q[RD_LATENCY-1:0], anyGrant & ~selWe};
      tagId_q  <= {tagId_q[RD_LATENCY-1:0], grant1};
    end
  end

  // The oldest tag lines up with the cycle in which mem_rdata carries its data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r0RspValid_q <= 1'b0;
      r1RspValid_q <= 1'b0;
      r0RspRdata_q <= '0;
      r1RspRdata_q <= '0;
    end else begin
      r0RspValid_q <= tagVld_q[RD_LATENCY] & ~tagId_q[RD_LATENCY];
      r1RspValid_q <= tagVld_q[RD_LATENCY] & tagId_q[RD_LATENCY];
      if (tagVld_q[RD_LATENCY] && !tagId_q[RD_LATENCY]) begin
        r0RspRdata_q <= mem_rdata_i;
      end
      if (tagVld_q[RD_LATENCY] && tagId_q[RD_LATENCY]) begin
        r1RspRdata_q <= mem_rdata_i;
      end
    end
  end

  assign r0_ready_o     = grant0;
  assign r1_ready_o     = grant1;
  assign mem_rd_en_o    = memRdEn_q;
  assign mem_wr_en_o    = memWrEn_q;
  assign mem_addr_o     = memAddr_q;
  assign mem_wdata_o    = memWdata_q;
  assign r0_rsp_valid_o = r0RspValid_q;
  assign r1_rsp_valid_o = r1RspValid_q;
  assign r0_rsp_rdata_o = r0RspRdata_q;
  assign r1_rsp_rdata_o = r1RspRdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter with a behavioural 16x16 memory behind it.
// Directed vectors carry hand-chosen grants; a monitor compares memory controls and responses as they appear.
module tb_mem_rr_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int RD_LATENCY = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r0Valid = 1'b0, r0We = 1'b0, r1Valid = 1'b0, r1We = 1'b0;
  logic [ADDR_W-1:0] r0Addr = '0, r1Addr = '0;
  logic [DATA_W-1:0] r0Wdata = '0, r1Wdata = '0;
  logic r0Ready, r1Ready, r0RspValid, r1RspValid;
  logic [DATA_W-1:0] r0RspRdata, r1RspRdata;
  logic memRdEn, memWrEn;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata, memRdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memExp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rspExp_t;

  memExp_t memQ[$];
  rspExp_t rspQ0[$];
  rspExp_t rspQ1[$];
  logic [DATA_W-1:0] refMem[16];
  logic [DATA_W-1:0] memArr[16];
  logic [DATA_W-1:0] memPipe[RD_LATENCY];
  logic [ADDR_W-1:0] expAddr = '0;
  logic [DATA_W-1:0] expWdata = '0;

  mem_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) dut (
    .clk_i(clk), .reset_i(reset),
    .r0_valid_i(r0Valid), .r0_ready_o(r0Ready), .r0_we_i(r0We), .r0_addr_i(r0Addr),
    .r0_wdata_i(r0Wdata), .r0_rsp_valid_o(r0RspValid), .r0_rsp_rdata_o(r0RspRdata),
    .r1_valid_i(r1Valid), .r1_ready_o(r1Ready), .r1_we_i(r1We), .r1_addr_i(r1Addr),
    .r1_wdata_i(r1Wdata), .r1_rsp_valid_o(r1RspValid), .r1_rsp_rdata_o(r1RspRdata),
    .mem_rd_en_o(memRdEn), .mem_wr_en_o(memWrEn), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) begin
      memArr[i] = '0;
      refMem[i] = '0;
    end
    for (int i = 0; i < RD_LATENCY; i++) memPipe[i] = '0;
  end

  // Synchronous memory: read data appears RD_LATENCY cycles after rd_en is sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memWrEn === 1'b1) memArr[memAddr] <= memWdata;
    if (memRdEn === 1'b1) memPipe[0] <= memArr[memAddr];
    for (int i = 1; i < RD_LATENCY; i++) memPipe[i] <= memPipe[i-1];
  end
  assign memRdata = memPipe[RD_LATENCY-1];

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checkRsp(input int id, input logic v, input logic [DATA_W-1:0] d);
    rspExp_t e;
    if (v === 1'b1) begin
      if ((id == 0 && rspQ0.size() == 0) || (id == 1 && rspQ1.size() == 0)) begin
        checks++;
        errors++;
        $display("[TB] FAIL r%0d_rsp_unexpected: got pulse data %h expected no pulse (cycle %0d)", id, d, cyc);
      end else begin
        e = (id == 0) ? rspQ0.pop_front() : rspQ1.pop_front();
        checkOutput($sformatf("r%0d_rsp_rdata", id), d, e.data);
        checkOutput($sformatf("r%0d_rsp_cycle", id), DATA_W'(cyc), DATA_W'(e.due));
      end
    end
  endtask

  // Monitor: memory controls every cycle, responses whenever a pulse appears.
  always @(posedge clk) begin
    memExp_t e;
    #1;
    if (memQ.size() > 0) begin
      e = memQ.pop_front();
      checkOutput("mem_rd_wr_en", {14'd0, memRdEn, memWrEn}, {14'd0, e.rd, e.wr});
      checkOutput("mem_addr", {12'd0, memAddr}, {12'd0, e.addr});
      checkOutput("mem_wdata", memWdata, e.wdata);
    end
    checkRsp(0, r0RspValid, r0RspRdata);
    checkRsp(1, r1RspValid, r1RspRdata);
  end

  // One cycle: drive both requesters, check ready against the hand-chosen grant, queue expectations.
  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic we0, input logic [ADDR_W-1:0] a0,
                               input logic [DATA_W-1:0] d0,
                               input logic v1, input logic we1, input logic [ADDR_W-1:0] a1,
                               input logic [DATA_W-1:0] d1,
                               input logic g0, input logic g1);
    rspExp_t r;
    logic w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    reset = rst;
    r0Valid = v0; r0We = we0; r0Addr = a0; r0Wdata = d0;
    r1Valid = v1; r1We = we1; r1Addr = a1; r1Wdata = d1;
    #1;
    checkOutput("r0_ready", {15'd0, r0Ready}, {15'd0, g0});
    checkOutput("r1_ready", {15'd0, r1Ready}, {15'd0, g1});
    if (rst) begin
      expAddr = '0;
      expWdata = '0;
      memQ.push_back('{1'b0, 1'b0, '0, '0});
      rspQ0.delete();
      rspQ1.delete();
    end else if (g0 || g1) begin
      w = g1 ? we1 : we0;
      a = g1 ? a1 : a0;
      d = g1 ? d1 : d0;
      expAddr = a;
      expWdata = d;
      memQ.push_back('{~w, w, a, d});
      if (w) begin
        refMem[a] = d;
      end else begin
        r.data = refMem[a];
        r.due = cyc + 2 + RD_LATENCY;
        if (g1) rspQ1.push_back(r);
        else rspQ0.push_back(r);
      end
    end else begin
      memQ.push_back('{1'b0, 1'b0, expAddr, expWdata});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with both requesters asking: nobody is granted.
    applyStimulus(1, 1, 0, 4'h1, 0, 1, 0, 4'h2, 0, 0, 0);
    applyStimulus(1, 1, 0, 4'h1, 0, 1, 0, 4'h2, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_rsp_rdata_reset", r0RspRdata, 16'h0000);
    checkOutput("r1_rsp_rdata_reset", r1RspRdata, 16'h0000);

    // Single write then read-back by r0.
    applyStimulus(0, 1, 1, 4'h3, 16'hA5A5, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 4'h3, 16'h0000, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Full sweep: r0 fills memory, r1 reads it back-to-back.
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1, 1, ADDR_W'(i), DATA_W'(i) * 16'h1111, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 0, 0, 0, 1, 0, ADDR_W'(i), 0, 0, 1);
    idle(4);

    // Continuous contention alternates, pointer starts at 0 after r1's last grant.
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 0, 4'h1, 0, 1, 0, 4'h2, 0, (i % 2) == 0, (i % 2) == 1);
    idle(4);

    // Pointer hold: r1 alone three times, then contention starts with r0.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'h5, 0, 0, 1);
    applyStimulus(0, 1, 0, 4'h6, 0, 1, 0, 4'h7, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'h7, 0, 0, 1);
    idle(4);

    // Reset right after a read is accepted: the read must vanish.
    applyStimulus(0, 1, 0, 4'h9, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);

    // After reset r0 wins first; r1's read after r0's held write sees the new data.
    applyStimulus(0, 1, 0, 4'hA, 0, 1, 0, 4'hB, 0, 1, 0);
    applyStimulus(0, 1, 1, 4'h4, 16'hBEEF, 1, 0, 4'hC, 0, 0, 1);
    applyStimulus(0, 1, 1, 4'h4, 16'hBEEF, 1, 0, 4'h4, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'h4, 0, 0, 1);
    idle(5);
    @(posedge clk);
    #2;

    checkOutput("r0_rsp_outstanding", DATA_W'(rspQ0.size()), 16'd0);
    checkOutput("r1_rsp_outstanding", DATA_W'(rspQ1.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
